rv_dmem_ctrl: RTL

// - Synthesizable, parametrised data memory for the rv_cpu MA stage (Q103H).
// - Replaces the flat word-only RAM model used in simulation.
// - Adds valid/ready request handshake, byte/half/word stores via byte lanes, sign/zero-extended loads,

---
 rtl/rv_dmem_ctrl_pkg.sv | 37 +++
 rtl/rv_dmem_ctrl_ram.sv | 26 ++
 rtl/rv_dmem_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv_dmem_ctrl_pkg.sv
// Shared types and the load-extension helper for the rv_cpu data memory controller.
package rv_dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_RSV = 2'b11
  } t_mem_size;

  typedef struct packed {
    t_mem_size  size;
    logic [1:0] lane;
    logic       unsigned_ld;
    logic       err;
    logic       wr;
  } t_dmem_meta;

  typedef enum logic {
    DMEM_INIT,
    DMEM_RUN
  } t_dmem_state;

  // Select the addressed lane of a raw array word and sign/zero-extend it.
  function automatic logic [31:0] dmem_extend(input logic [31:0] word, input t_dmem_meta meta);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{meta.lane, 3'b000} +: 8];
    h = word[{meta.lane[1], 4'b0000} +: 16];
    case (meta.size)
      MEM_B:   dmem_extend = {{24{~meta.unsigned_ld & b[7]}}, b};
      MEM_H:   dmem_extend = {{16{~meta.unsigned_ld & h[15]}}, h};
      default: dmem_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/rv_dmem_ctrl_ram.sv
// DEPTH_WORDS x 32 single-port RAM with per-byte write enables and a registered read port.
module rv_dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rv_dmem_ctrl.sv
// Data memory for the rv_cpu MA stage: valid/ready requests, byte-lane stores,
// extended loads, zero-fill init and a fixed-latency in-order response pipe.
module rv_dmem_ctrl
  import rv_dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wr_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd_data,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  t_dmem_state     r_state, w_state_nxt;
  logic [AW-1:0]   r_init_cnt;
  logic            r_ready;

  logic            w_accept;
  logic [32:0]     w_off_full;
  logic [1:0]      w_lane;
  t_mem_size       w_size;
  logic            w_oor, w_misalign, w_err;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_be;
  logic [31:0]     w_st_data;
  t_dmem_meta      w_meta;

  logic            w_ram_en;
  logic [3:0]      w_ram_we;
  logic [AW-1:0]   w_ram_addr;
  logic [31:0]     w_ram_wdata;
  logic [31:0]     w_ram_rdata;

  t_dmem_meta             r_meta [RD_LATENCY];
  logic [RD_LATENCY-1:0]  r_vld;
  logic [31:0]            w_stage0_data;

  assign w_accept  = req_valid & r_ready;
  assign req_ready = r_ready;

  // 33-bit subtract: bit 32 is the borrow that flags addresses below BASE_ADDR.
  assign w_off_full = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign w_lane     = w_off_full[1:0];
  assign w_idx      = w_off_full[AW+1:2];
  assign w_size     = t_mem_size'(req_size);
  assign w_oor      = w_off_full[32] | (w_off_full[31:2] >= 30'(DEPTH_WORDS));
  assign w_misalign = ((w_size == MEM_H) & w_lane[0]) | ((w_size == MEM_W) & (w_lane != 2'b00));
  assign w_err      = w_oor | w_misalign | (w_size == MEM_RSV);

  always_comb begin
    w_be      = '0;
    w_st_data = req_wr_data;
    case (w_size)
      MEM_B: begin
        w_be      = 4'b0001 << w_lane;
        w_st_data = {4{req_wr_data[7:0]}};
      end
      MEM_H: begin
        w_be      = 4'b0011 << w_lane;
        w_st_data = {2{req_wr_data[15:0]}};
      end
      MEM_W:   w_be = 4'hF;
      MEM_RSV: w_be = '0;
    endcase
  end

  assign w_meta = '{size: w_size, lane: w_lane, unsigned_ld: req_unsigned, err: w_err, wr: req_wr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= (INIT_ZERO != 0) ? DMEM_INIT : DMEM_RUN;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == DMEM_RUN);
      if (r_state == DMEM_INIT) r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = '0;
    w_ram_addr  = w_idx;
    w_ram_wdata = w_st_data;
    case (r_state)
      DMEM_INIT: begin
        w_ram_we    = '1;
        w_ram_addr  = r_init_cnt;
        w_ram_wdata = '0;
        if (r_init_cnt == AW'(DEPTH_WORDS - 1)) w_state_nxt = DMEM_RUN;
      end
      DMEM_RUN: begin
        w_ram_en = w_accept;
        if (w_accept & req_wr & ~w_err) w_ram_we = w_be;
      end
    endcase
  end

  rv_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) r_meta[i] <= '0;
    end else begin
      r_vld[0]  <= w_accept;
      r_meta[0] <= w_meta;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_meta[i] <= r_meta[i-1];
      end
    end
  end

  // The RAM output is only stable for one cycle, so extended data is captured at stage 0.
  assign w_stage0_data = (r_vld[0] & ~r_meta[0].wr & ~r_meta[0].err) ?
                         dmem_extend(w_ram_rdata, r_meta[0]) : '0;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign rsp_rd_data = w_stage0_data;
    end else begin : g_latn
      logic [31:0] r_data [RD_LATENCY-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < RD_LATENCY - 1; i++) r_data[i] <= '0;
        end else begin
          r_data[0] <= w_stage0_data;
          for (int unsigned i = 1; i < RD_LATENCY - 1; i++) r_data[i] <= r_data[i-1];
        end
      end
      assign rsp_rd_data = r_data[RD_LATENCY-2];
    end
  endgenerate

  assign rsp_valid = r_vld[RD_LATENCY-1];
  assign rsp_err   = r_vld[RD_LATENCY-1] & r_meta[RD_LATENCY-1].err;

endmodule
